// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle sequencer and the shared
// datapath plus memory port. The sequencer side is the master.
interface multicycle_control_fsm_if #(
  parameter int BITS = 32
);
  logic [BITS-1:0] Instruction;
  logic            Zero;
  logic            MemReady;
  logic            PCWrite;
  logic            IRWrite;
  logic            AdrSrc;
  logic            MemReq;
  logic            MemWrite;
  logic            RegWrite;
  logic [1:0]      ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUControl;
  logic [1:0]      ResultSrc;
  logic            Fault;
  logic [3:0]      State;

  modport master (
    input  Instruction, Zero, MemReady,
    output PCWrite, IRWrite, AdrSrc, MemReq, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, Fault, State
  );

  modport slave (
    output Instruction, Zero, MemReady,
    input  PCWrite, IRWrite, AdrSrc, MemReq, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, Fault, State
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle RV32I core: walks the shared datapath
// through fetch/decode/execute/memory/writeback, one state per clock, and
// faults on unsupported instructions or a memory port that never answers.
module multicycle_control_fsm #(
  parameter int BITS        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    WB_ALU   = 4'd8,
    BRANCH   = 4'd9,
    FAULT    = 4'd15
  } state_t;

  localparam logic [4:0] OP_R  = 5'b01100;
  localparam logic [4:0] OP_I  = 5'b00100;
  localparam logic [4:0] OP_LW = 5'b00000;
  localparam logic [4:0] OP_SW = 5'b01000;
  localparam logic [4:0] OP_BR = 5'b11000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Last counter value before the wait budget is used up.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t          state, state_next;
  logic [7:0]      wait_cnt, wait_cnt_next;
  logic [BITS-1:0] instr;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic            sub_bit;
  logic            alu_f3_ok, br_f3_ok;
  logic            mem_state, timeout;
  logic            unused_instr_bits;

  assign instr     = bus.Instruction;
  assign opcode    = instr[6:2];
  assign funct3    = instr[14:12];
  assign sub_bit   = instr[30];
  assign alu_f3_ok = funct3 inside {3'b000, 3'b110, 3'b111};
  assign br_f3_ok  = funct3 inside {3'b000, 3'b001};
  assign unused_instr_bits = ^{instr[BITS-1:31], instr[29:15], instr[11:7], instr[1:0]};

  // States that hold a memory request open until MemReady.
  assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeout   = mem_state && !bus.MemReady && (wait_cnt == WAIT_LAST);

  function automatic logic [1:0] alu_for(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      default: return sub ? ALU_SUB : ALU_ADD;
    endcase
  endfunction

  // State register and memory wait counter.
  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // the state only returns to FETCH on the next rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state selection and wait-counter update.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_next = state;
    case (state)
      FETCH:    if (bus.MemReady) state_next = DECODE;
                else if (timeout) state_next = FAULT;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_R:         state_next = alu_f3_ok ? EXEC_R : FAULT;
          OP_I:         state_next = alu_f3_ok ? EXEC_I : FAULT;
          OP_BR:        state_next = br_f3_ok  ? BRANCH : FAULT;
          default:      state_next = FAULT;
        endcase
      end
      MEM_ADDR: state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (bus.MemReady) state_next = WB_MEM;
                else if (timeout) state_next = FAULT;
      MEM_WR:   if (bus.MemReady) state_next = FETCH;
                else if (timeout) state_next = FAULT;
      WB_MEM:   state_next = FETCH;
      EXEC_R:   state_next = WB_ALU;
      EXEC_I:   state_next = WB_ALU;
      WB_ALU:   state_next = FETCH;
      BRANCH:   state_next = FETCH;
      FAULT:    state_next = FAULT;
      default:  state_next = FAULT;
    endcase

    // Count stalled cycles; any completion or state change restarts the count.
    if (mem_state && !bus.MemReady && (state_next == state)) begin
      wait_cnt_next = wait_cnt + 8'd1;
    end else begin
      wait_cnt_next = '0;
    end
  end

  // Moore datapath controls, plus the FETCH/BRANCH write strobes that
  // depend on MemReady and Zero in the current cycle.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemReq     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_REG;
    bus.ALUControl = ALU_ADD;
    bus.ResultSrc  = RES_ALUOUT;
    bus.Fault      = 1'b0;
    case (state)
      FETCH: begin
        bus.MemReq    = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
      end
      DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      MEM_ADDR: begin
        bus.ALUSrcA = SRCA_REG;
        bus.ALUSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
      end
      WB_MEM: begin
        bus.ResultSrc = RES_MEM;
        bus.RegWrite  = 1'b1;
      end
      MEM_WR: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
      end
      EXEC_R: begin
        bus.ALUSrcA    = SRCA_REG;
        bus.ALUControl = alu_for(funct3, sub_bit);
      end
      EXEC_I: begin
        bus.ALUSrcA    = SRCA_REG;
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = alu_for(funct3, 1'b0);
      end
      WB_ALU: bus.RegWrite = 1'b1;
      BRANCH: begin
        bus.ALUSrcA    = SRCA_REG;
        bus.ALUControl = ALU_SUB;
        bus.PCWrite    = (funct3 == 3'b000) ? bus.Zero : !bus.Zero;
      end
      FAULT:   bus.Fault = 1'b1;
      default: bus.Fault = 1'b0;
    endcase

    // Reset aborts any transaction immediately, including an open request.
    if (rst) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemReq   = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end

  assign bus.State = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle sequencer. A route-based reference model
// predicts the state sequence per instruction; a compare process checks every
// output on every falling edge, and directed tests pin the model with literals.
module tb_multicycle_control_fsm;

  localparam int MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.BITS(32)) bus ();

  multicycle_control_fsm #(.BITS(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef int route_t [4];
  typedef struct packed {
    logic       pcw, irw, adr, req, wr, regw;
    logic [1:0] a, b, alu, res;
    logic       flt;
    logic [3:0] st;
  } outs_t;

  // Sequence of states visited after FETCH; 0 ends the instruction.
  function automatic route_t route_of(input logic [31:0] ins);
    logic [4:0] op = ins[6:2];
    logic [2:0] f3 = ins[14:12];
    logic alu_ok = (f3 == 3'd0) || (f3 == 3'd6) || (f3 == 3'd7);
    logic br_ok  = (f3 == 3'd0) || (f3 == 3'd1);
    route_t r = '{1, 15, 15, 15};
    if (op == 5'b00000)                r = '{1, 2, 3, 4};
    else if (op == 5'b01000)           r = '{1, 2, 5, 0};
    else if (op == 5'b01100 && alu_ok) r = '{1, 6, 8, 0};
    else if (op == 5'b00100 && alu_ok) r = '{1, 7, 8, 0};
    else if (op == 5'b11000 && br_ok)  r = '{1, 9, 0, 0};
    return r;
  endfunction

  function automatic logic [1:0] exp_alu(input logic [31:0] ins, input logic use_sub);
    logic [2:0] f3 = ins[14:12];
    if (f3 == 3'd7) return 2'b10;
    if (f3 == 3'd6) return 2'b11;
    return (use_sub && ins[30]) ? 2'b01 : 2'b00;
  endfunction

  function automatic outs_t exp_out(input int st, input logic [31:0] ins,
                                    input logic mr, input logic z, input logic r);
    outs_t o = '0;
    o.st = 4'(st);
    case (st)
      0:  begin o.req = 1; o.b = 2; o.res = 2; o.irw = mr; o.pcw = mr; end
      1:  begin o.a = 1; o.b = 1; end
      2:  begin o.a = 2; o.b = 1; end
      3:  begin o.req = 1; o.adr = 1; end
      4:  begin o.res = 1; o.regw = 1; end
      5:  begin o.req = 1; o.wr = 1; o.adr = 1; end
      6:  begin o.a = 2; o.alu = exp_alu(ins, 1'b1); end
      7:  begin o.a = 2; o.b = 1; o.alu = exp_alu(ins, 1'b0); end
      8:  o.regw = 1;
      9:  begin o.a = 2; o.alu = 2'b01; o.pcw = ins[12] ? !z : z; end
      15: o.flt = 1;
      default: o.st = 4'(st);
    endcase
    if (r) begin o.pcw = 0; o.irw = 0; o.req = 0; o.wr = 0; o.regw = 0; end
    return o;
  endfunction

  int exp_state = 0;
  int pos       = 0;
  int waits     = 0;

  always @(posedge clk) begin
    int ns, np, nw;
    route_t r;
    ns = exp_state; np = pos; nw = waits;
    r  = route_of(bus.Instruction);
    if (rst) begin
      ns = 0; np = 0; nw = 0;
    end else if (exp_state == 15) begin
      ns = 15;
    end else if ((exp_state == 0 || exp_state == 3 || exp_state == 5) && !bus.MemReady) begin
      nw = waits + 1;
      if (nw == MEM_TIMEOUT) begin ns = 15; nw = 0; end
    end else begin
      nw = 0;
      if (exp_state == 0) begin ns = r[0]; np = 1; end
      else if (pos > 3)   begin ns = 0; end
      else                begin ns = r[pos]; np = pos + 1; end
    end
    exp_state <= ns; pos <= np; waits <= nw;
  end

  // Per-cycle compare of every output against the model.
  logic check_on = 1'b0;
  always @(negedge clk) begin
    outs_t got, expv;
    if (check_on) begin
      got  = {bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemReq, bus.MemWrite, bus.RegWrite,
              bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ResultSrc, bus.Fault, bus.State};
      expv = exp_out(exp_state, bus.Instruction, bus.MemReady, bus.Zero, rst);
      check("cycle_outputs", 32'(got), 32'(expv));
    end
  end

  // ---------------- directed stimulus ----------------
  int          cycles, irw_cnt, regw_cnt;
  logic [31:0] trace;
  logic [1:0]  regw_res, alu_exec;
  logic [3:0]  regw_state;
  logic        pcw_branch, abort_req, abort_wr;
  logic [3:0]  abort_st;

  // Runs one instruction from FETCH; called and returns one step after a rising edge.
  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw,
                          input logic z, input int abort_state);
    int  fw_left = fw;
    int  mw_left = mw;
    bit  left    = 0;
    cycles = 0; irw_cnt = 0; regw_cnt = 0; trace = '0;
    regw_res = '0; regw_state = '0; alu_exec = '1; pcw_branch = 1'bx;
    bus.Instruction = ins;
    bus.Zero        = z;
    while (cycles < 100) begin
      if (exp_state == abort_state) begin
        rst = 1'b1;
        bus.MemReady = 1'b0;
        @(negedge clk);
        abort_req = bus.MemReq; abort_wr = bus.MemWrite; abort_st = bus.State;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (exp_state == 0) begin
        bus.MemReady = (fw_left == 0);
        if (fw_left > 0) fw_left--;
      end else if (exp_state == 3 || exp_state == 5) begin
        bus.MemReady = (mw_left == 0);
        if (mw_left > 0) mw_left--;
      end else begin
        bus.MemReady = 1'b1;
      end
      @(negedge clk);
      trace = {trace[27:0], bus.State};
      if (bus.IRWrite) irw_cnt++;
      if (bus.RegWrite) begin regw_cnt++; regw_res = bus.ResultSrc; regw_state = bus.State; end
      if (bus.State == 4'd9) pcw_branch = bus.PCWrite;
      if (bus.State == 4'd6 || bus.State == 4'd7) alu_exec = bus.ALUControl;
      @(posedge clk); #1;
      cycles++;
      if (exp_state != 0) left = 1;
      if (left && (exp_state == 0 || exp_state == 15)) return;
    end
    check("cycle_budget", 32'(cycles), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.MemReady = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bus.Instruction = '0;
    bus.Zero        = 1'b0;
    bus.MemReady    = 1'b0;
    @(posedge clk); #1;
    check_on = 1'b1;
    @(posedge clk); #1;
    check("reset_state", 32'(bus.State), 32'd0);
    check("reset_fault", 32'(bus.Fault), 32'd0);
    check("reset_strobes", 32'({bus.PCWrite, bus.IRWrite, bus.MemReq, bus.MemWrite, bus.RegWrite}), 32'd0);
    rst = 1'b0;

    // add x3,x1,x2
    do_instr(32'h002081B3, 0, 0, 1'b0, -1);
    check("add_cycles", 32'(cycles), 32'd4);
    check("add_trace", trace, 32'h0000_0168);
    check("add_alu", 32'(alu_exec), 32'd0);
    check("add_regw_cnt", 32'(regw_cnt), 32'd1);
    check("add_regw_state", 32'(regw_state), 32'd8);
    check("add_irw_cnt", 32'(irw_cnt), 32'd1);

    // sub, addi with bit 30 set, and, ori
    do_instr(32'h402081B3, 0, 0, 1'b0, -1);
    check("sub_alu", 32'(alu_exec), 32'd1);
    do_instr(32'h40008093, 0, 0, 1'b0, -1);
    check("addi30_alu", 32'(alu_exec), 32'd0);
    check("addi_trace", trace, 32'h0000_0178);
    do_instr(32'h0020F1B3, 0, 0, 1'b0, -1);
    check("and_alu", 32'(alu_exec), 32'd2);
    do_instr(32'h0060E093, 0, 0, 1'b0, -1);
    check("ori_alu", 32'(alu_exec), 32'd3);

    // lw with 3 fetch waits and 2 read waits
    do_instr(32'h0000A183, 3, 2, 1'b0, -1);
    check("lw_cycles", 32'(cycles), 32'd10);
    check("lw_trace", trace, 32'h0012_3334);
    check("lw_irw_cnt", 32'(irw_cnt), 32'd1);
    check("lw_regw_cnt", 32'(regw_cnt), 32'd1);
    check("lw_regw_res", 32'(regw_res), 32'd1);

    // beq / bne with both Zero values
    do_instr(32'h00208463, 0, 0, 1'b1, -1);
    check("beq_z1_pcw", 32'(pcw_branch), 32'd1);
    check("beq_cycles", 32'(cycles), 32'd3);
    check("beq_trace", trace, 32'h0000_0019);
    do_instr(32'h00208463, 0, 0, 1'b0, -1);
    check("beq_z0_pcw", 32'(pcw_branch), 32'd0);
    do_instr(32'h00209463, 0, 0, 1'b1, -1);
    check("bne_z1_pcw", 32'(pcw_branch), 32'd0);
    do_instr(32'h00209463, 0, 0, 1'b0, -1);
    check("bne_z0_pcw", 32'(pcw_branch), 32'd1);

    // sw with waits one short of the budget in both request states
    do_instr(32'h0020A223, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0, -1);
    check("sw_long_cycles", 32'(cycles), 32'd32);
    check("sw_long_trace", trace, 32'h5555_5555);
    check("sw_long_nofault", 32'(bus.Fault), 32'd0);

    // Unsupported funct3 and opcode
    do_instr(32'h0020C1B3, 0, 0, 1'b0, -1);
    check("xor_trace", trace, 32'h0000_0001);
    check("xor_fault", 32'(bus.Fault), 32'd1);
    pulse_reset();
    do_instr(32'h0000006F, 0, 0, 1'b0, -1);
    check("jal_trace", trace, 32'h0000_0001);
    check("jal_state", 32'(bus.State), 32'd15);
    pulse_reset();

    // Fetch timeout
    bus.MemReady = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.State != 4'd0) break;
      n++;
    end
    check("timeout_waits", 32'(n), 32'(MEM_TIMEOUT));
    check("timeout_state", 32'(bus.State), 32'd15);
    @(posedge clk); #1;
    bus.MemReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fault_sticky", 32'(bus.Fault), 32'd1);
    pulse_reset();
    check("fault_cleared", 32'(bus.Fault), 32'd0);
    check("fault_reset_state", 32'(bus.State), 32'd0);

    // Reset in the middle of a store
    do_instr(32'h0020A223, 0, 5, 1'b0, 5);
    check("abort_seen_state", 32'(abort_st), 32'd5);
    check("abort_memreq", 32'(abort_req), 32'd0);
    check("abort_memwrite", 32'(abort_wr), 32'd0);
    check("abort_next_state", 32'(bus.State), 32'd0);

    // One clean instruction after the abort
    do_instr(32'h002081B3, 0, 0, 1'b0, -1);
    check("post_abort_trace", trace, 32'h0000_0168);

    @(negedge clk);
    check_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
